// File: rtl/tone_bank.sv
// tone_bank: NUM_CH independent square-wave tone channels. Each channel has a
// runtime-programmable half-period divisor and a true 50 % duty cycle. A
// note-off never cuts a high phase short. A registered popcount of the tone
// vector is provided for downstream mixing.
module tone_bank #(
    parameter int NUM_CH      = 8,
    parameter int DIV_W       = 17,
    parameter int DEFAULT_DIV = 47774,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W      = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] tone,
    output logic [NUM_CH-1:0] active,
    output logic [MIX_W-1:0]  mix
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ZERO_DIV  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE_DIV   = {{(DIV_W-1){1'b0}}, 1'b1};

    // Number of set bits in the tone vector.
    function automatic logic [MIX_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [MIX_W-1:0] c;
        c = {MIX_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + {{(MIX_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    state_t            state_r [NUM_CH];
    logic [DIV_W-1:0]  pdiv_r  [NUM_CH];
    logic [DIV_W-1:0]  adiv_r  [NUM_CH];
    logic [DIV_W-1:0]  cnt_r   [NUM_CH];
    logic [NUM_CH-1:0] tone_r;
    logic [NUM_CH-1:0] active_r;
    logic [MIX_W-1:0]  mix_r;

    logic [NUM_CH-1:0] wrap_s;
    logic [NUM_CH-1:0] tone_step_s;
    logic [DIV_W-1:0]  cnt_step_s  [NUM_CH];
    logic [DIV_W-1:0]  adiv_step_s [NUM_CH];

    // Pending divisors: a zero divisor is stored as 1, writes to channel
    // indices that do not exist never match any channel and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pdiv_r[i] <= DEF_DIV_V;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && (wr_ch == CH_W'(i))) begin
                    pdiv_r[i] <= (wr_div == ZERO_DIV) ? ONE_DIV : wr_div;
                end else begin
                    pdiv_r[i] <= pdiv_r[i];
                end
            end
        end
    end

    // Count step shared by RUN and DRAIN: wrap toggles tone and loads the
    // pending divisor so both phases of a half-period use one divisor.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrap_s[i] = (cnt_r[i] == (adiv_r[i] - ONE_DIV));
            if (wrap_s[i]) begin
                cnt_step_s[i]  = ZERO_DIV;
                tone_step_s[i] = ~tone_r[i];
                adiv_step_s[i] = pdiv_r[i];
            end else begin
                cnt_step_s[i]  = cnt_r[i] + ONE_DIV;
                tone_step_s[i] = tone_r[i];
                adiv_step_s[i] = adiv_r[i];
            end
        end
    end

    // Per-channel IDLE/RUN/DRAIN state machine with registered tone/active.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= ZERO_DIV;
                adiv_r[i]  <= DEF_DIV_V;
            end
            tone_r   <= {NUM_CH{1'b0}};
            active_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_r[i])
                    ST_IDLE: begin
                        cnt_r[i]    <= ZERO_DIV;
                        tone_r[i]   <= 1'b0;
                        adiv_r[i]   <= pdiv_r[i];
                        active_r[i] <= en[i];
                        state_r[i]  <= en[i] ? ST_RUN : ST_IDLE;
                    end
                    ST_RUN: begin
                        if (en[i]) begin
                            cnt_r[i]    <= cnt_step_s[i];
                            tone_r[i]   <= tone_step_s[i];
                            adiv_r[i]   <= adiv_step_s[i];
                            active_r[i] <= 1'b1;
                            state_r[i]  <= ST_RUN;
                        end else if (!tone_r[i]) begin
                            // Low phase: the note can stop immediately.
                            cnt_r[i]    <= ZERO_DIV;
                            tone_r[i]   <= 1'b0;
                            adiv_r[i]   <= adiv_r[i];
                            active_r[i] <= 1'b0;
                            state_r[i]  <= ST_IDLE;
                        end else begin
                            // High phase: finish it; stop on the falling wrap.
                            cnt_r[i]    <= cnt_step_s[i];
                            tone_r[i]   <= tone_step_s[i];
                            adiv_r[i]   <= adiv_step_s[i];
                            active_r[i] <= ~wrap_s[i];
                            state_r[i]  <= wrap_s[i] ? ST_IDLE : ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        cnt_r[i]  <= cnt_step_s[i];
                        tone_r[i] <= tone_step_s[i];
                        adiv_r[i] <= adiv_step_s[i];
                        if (en[i]) begin
                            active_r[i] <= 1'b1;
                            state_r[i]  <= ST_RUN;
                        end else begin
                            active_r[i] <= ~wrap_s[i];
                            state_r[i]  <= wrap_s[i] ? ST_IDLE : ST_DRAIN;
                        end
                    end
                    default: begin
                        cnt_r[i]    <= ZERO_DIV;
                        tone_r[i]   <= 1'b0;
                        adiv_r[i]   <= pdiv_r[i];
                        active_r[i] <= 1'b0;
                        state_r[i]  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Mixer count, one cycle behind the registered tone vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            mix_r <= {MIX_W{1'b0}};
        end else begin
            mix_r <= popcount(tone_r);
        end
    end

    assign tone   = tone_r;
    assign active = active_r;
    assign mix    = mix_r;

endmodule

// File: tb/tb_tone_bank.sv
// Testbench for tone_bank: NUM_CH=6, DEFAULT_DIV=4. A cycle model predicts
// every output per edge into a scoreboard queue; scenario tasks additionally
// check the key edge positions directly.
module tb_tone_bank;

    localparam int NCH  = 6;
    localparam int DW   = 17;
    localparam int DDIV = 4;
    localparam int CW   = 3;
    localparam int MW   = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           wr_en;
    logic [CW-1:0]  wr_ch;
    logic [DW-1:0]  wr_div;
    logic [NCH-1:0] tone;
    logic [NCH-1:0] active;
    logic [MW-1:0]  mix;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tone_bank #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .tone(tone), .active(active), .mix(mix)
    );

    // Reference model: state 0=idle 1=run 2=drain; rem = edges left in the
    // current half-period.
    int             m_st   [NCH] = '{default: 0};
    int             m_rem  [NCH] = '{default: 0};
    int             m_pdiv [NCH] = '{default: DDIV};
    logic [NCH-1:0] m_tone = '0;
    logic [NCH-1:0] m_act  = '0;
    logic [MW-1:0]  m_mix  = '0;
    logic [2*NCH+MW-1:0] exp_q [$];
    logic [2*NCH+MW-1:0] exp_v;
    bit             m_wrap;
    int             m_pc;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_st[i] = 0; m_rem[i] = 0; m_pdiv[i] = DDIV;
            end
            m_tone = '0; m_act = '0; m_mix = '0;
        end else begin
            m_pc = 0;
            for (int i = 0; i < NCH; i++) m_pc += int'(m_tone[i]);
            m_mix = MW'(m_pc);
            for (int i = 0; i < NCH; i++) begin
                m_wrap = (m_rem[i] == 1);
                if (m_st[i] == 0) begin
                    if (en[i]) begin m_st[i] = 1; m_rem[i] = m_pdiv[i]; m_act[i] = 1'b1; end
                end else if (en[i]) begin
                    m_st[i] = 1; m_act[i] = 1'b1;
                    if (m_wrap) begin m_tone[i] = ~m_tone[i]; m_rem[i] = m_pdiv[i]; end
                    else m_rem[i]--;
                end else if (!m_tone[i]) begin
                    m_st[i] = 0; m_act[i] = 1'b0;
                end else if (m_wrap) begin
                    m_st[i] = 0; m_act[i] = 1'b0; m_tone[i] = 1'b0;
                end else begin
                    m_st[i] = 2; m_rem[i]--;
                end
            end
            if (wr_en && int'(wr_ch) < NCH) m_pdiv[wr_ch] = (wr_div == 0) ? 1 : int'(wr_div);
        end
        exp_q.push_back({m_tone, m_act, m_mix});
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_empty t=%0t no expected entry", $time);
        end else begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (tone !== exp_v[2*NCH+MW-1 -: NCH]) begin
                n_fail++;
                $display("FAIL sb_tone t=%0t got %b want %b", $time, tone, exp_v[2*NCH+MW-1 -: NCH]);
            end
            n_checks++;
            if (active !== exp_v[NCH+MW-1 -: NCH]) begin
                n_fail++;
                $display("FAIL sb_active t=%0t got %b want %b", $time, active, exp_v[NCH+MW-1 -: NCH]);
            end
            n_checks++;
            if (mix !== exp_v[MW-1:0]) begin
                n_fail++;
                $display("FAIL sb_mix t=%0t got %0d want %0d", $time, mix, exp_v[MW-1:0]);
            end
        end
    end

    // Advance one edge; outputs are then read 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (tone !== 6'd0 || active !== 6'd0 || mix !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got tone=%b active=%b mix=%0d want 0", c, tone, active, mix);
            end
        end
    endtask

    task automatic test_basic();
        en[0] = 1'b1;
        tick();
        n_checks++;
        if (active[0] !== 1'b1 || tone[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start got active=%b tone=%b want 1 0", active[0], tone[0]);
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_checks++;
            if (tone[0] !== ((c >= 4 && c < 8) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL basic_tone k+%0d got %b want %b", c, tone[0], (c >= 4 && c < 8));
            end
        end
        en[0] = 1'b0;
        tick();
        n_checks++;
        if (active[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_stop got active=%b want 0", active[0]);
        end
        tick(); tick();
    endtask

    task automatic test_div_change();
        int tg [6] = '{3, 6, 9, 14, 19, 21};
        int nt;
        wr_en = 1'b1; wr_ch = 3'd2; wr_div = 17'd3;
        tick();
        wr_en = 1'b0; en[2] = 1'b1;
        tick();
        for (int c = 1; c <= 22; c++) begin
            if (c == 8) begin wr_en = 1'b1; wr_ch = 3'd2; wr_div = 17'd5; end
            else if (c == 14) begin wr_en = 1'b1; wr_ch = 3'd2; wr_div = 17'd2; end
            else wr_en = 1'b0;
            tick();
            nt = 0;
            for (int t = 0; t < 6; t++) if (tg[t] <= c) nt++;
            n_checks++;
            if (tone[2] !== ((nt % 2) == 1)) begin
                n_fail++;
                $display("FAIL div_change k+%0d got %b want %b", c, tone[2], ((nt % 2) == 1));
            end
        end
        wr_en = 1'b0; en[2] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_note_off();
        en[0] = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) en[0] = 1'b0;
            tick();
            n_checks++;
            if (tone[0] !== ((c >= 4 && c < 8) ? 1'b1 : 1'b0) || active[0] !== ((c < 8) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL note_off_high k+%0d got tone=%b active=%b want %b %b",
                         c, tone[0], active[0], (c >= 4 && c < 8), (c < 8));
            end
        end
        en[0] = 1'b1;
        tick(); tick();
        en[0] = 1'b0;
        tick();
        n_checks++;
        if (active[0] !== 1'b0 || tone[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL note_off_low got active=%b tone=%b want 0 0", active[0], tone[0]);
        end
        tick();
    endtask

    task automatic test_drain_reenable();
        en[0] = 1'b1;
        tick();
        for (int c = 1; c <= 17; c++) begin
            if (c == 5) en[0] = 1'b0;
            else en[0] = 1'b1;
            tick();
            n_checks++;
            if (tone[0] !== (((c / 4) % 2) == 1) || active[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_reenable k+%0d got tone=%b active=%b want %b 1",
                         c, tone[0], active[0], (((c / 4) % 2) == 1));
            end
        end
        en[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_all_mix();
        logic [NCH-1:0] et;
        logic [MW-1:0]  em;
        for (int i = 0; i < NCH; i++) begin
            wr_en = 1'b1; wr_ch = CW'(i); wr_div = 17'd2;
            tick();
        end
        wr_en = 1'b0; en = 6'h3F;
        tick();
        for (int c = 1; c <= 9; c++) begin
            tick();
            et = (c >= 2 && ((c - 2) / 2) % 2 == 0) ? 6'h3F : 6'h00;
            em = ((c - 1) >= 2 && ((c - 3) / 2) % 2 == 0) ? 3'd6 : 3'd0;
            n_checks++;
            if (tone !== et || mix !== em) begin
                n_fail++;
                $display("FAIL all_mix k+%0d got tone=%b mix=%0d want %b %0d", c, tone, mix, et, em);
            end
        end
        en = '0;
        repeat (3) tick();
    endtask

    task automatic test_div_zero();
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 17'd0;
        tick();
        wr_en = 1'b0; en[1] = 1'b1;
        tick();
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (tone[1] !== ((c % 2) == 1)) begin
                n_fail++;
                $display("FAIL div_zero k+%0d got %b want %b", c, tone[1], ((c % 2) == 1));
            end
        end
        en[1] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_bad_ch_and_reset_mid();
        wr_en = 1'b1; wr_ch = 3'd6; wr_div = 17'd9;
        tick();
        wr_ch = 3'd7; wr_div = 17'd11;
        tick();
        wr_en = 1'b0; en = 6'h3F;
        tick();
        tick();
        n_checks++;
        if (tone !== 6'b000010) begin
            n_fail++;
            $display("FAIL bad_ch_k1 got %b want 000010", tone);
        end
        tick();
        n_checks++;
        if (tone !== 6'b111101) begin
            n_fail++;
            $display("FAIL bad_ch_k2 got %b want 111101", tone);
        end
        reset = 1'b1; en = '0;
        tick();
        n_checks++;
        if (tone !== 6'd0 || active !== 6'd0 || mix !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid got tone=%b active=%b mix=%0d want 0", tone, active, mix);
        end
        reset = 1'b0; en = 6'b000110;
        tick();
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (tone !== ((c >= 4) ? 6'b000110 : 6'b000000)) begin
                n_fail++;
                $display("FAIL reset_div k+%0d got %b want %b", c, tone, ((c >= 4) ? 6'b000110 : 6'b000000));
            end
        end
        en = '0;
        repeat (6) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_div_change();
        test_note_off();
        test_drain_reenable();
        test_all_mix();
        test_div_zero();
        test_bad_ch_and_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
